// File: rtl/full_adder_pkg.sv
// Shared arithmetic helpers for the full_adder ripple chain.
// The bit cell is expressed through these so every cell uses one definition.
package full_adder_pkg;

  // Sum bit of a 1-bit full adder.
  function automatic logic fa_sum(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  // Carry bit of a 1-bit full adder (majority of the three inputs).
  function automatic logic fa_carry(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/full_adder_fa_bit.sv
// One-bit full-adder cell: the repeated element of the ripple chain.
module fa_bit
  import full_adder_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = fa_sum(a_i, b_i, cin_i);
  assign cout_o = fa_carry(a_i, b_i, cin_i);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with an optional one-cycle output register
// stage that captures only when in_valid is high.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             out_valid
);

  logic [WIDTH:0]   k_s;
  logic [WIDTH-1:0] s_s;

  assign k_s[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fa_bit u_fa_bit (
      .a_i    (a[i]),
      .b_i    (b[i]),
      .cin_i  (k_s[i]),
      .s_o    (s_s[i]),
      .cout_o (k_s[i+1])
    );
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_d,   sum_q;
    logic             c_out_d, c_out_q;
    logic             valid_d, valid_q;

    // Next-state: capture on in_valid, otherwise hold the last result.
    always_comb begin
      sum_d   = sum_q;
      c_out_d = c_out_q;
      valid_d = in_valid;
      if (in_valid) begin
        sum_d   = s_s;
        c_out_d = k_s[WIDTH];
      end else begin
        sum_d   = sum_q;
        c_out_d = c_out_q;
      end
    end

    // Output register; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= {WIDTH{1'b0}};
        c_out_q <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        sum_q   <= sum_d;
        c_out_q <= c_out_d;
        valid_q <= valid_d;
      end
    end

    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    // Clock and reset have no role in the combinational variant.
    logic unused_clk_rst_s;
    assign unused_clk_rst_s = clk ^ rst_n;

    assign sum       = s_s;
    assign c_out     = k_s[WIDTH];
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench: four full_adder configurations against an arithmetic
// reference model and the WIDTH=1 truth table.
module tb_full_adder;

  logic clk;
  logic rst_n;

  // WIDTH=1, registered
  logic       v1, a1, b1, ci1, s1, co1, ov1;
  // WIDTH=8, registered
  logic       v8, ci8, co8, ov8;
  logic [7:0] a8, b8, s8;
  // WIDTH=4, combinational
  logic       v4, ci4, co4, ov4;
  logic [3:0] a4, b4, s4;
  // WIDTH=16, registered
  logic        v16, ci16, co16, ov16;
  logic [15:0] a16, b16, s16;

  int n_checks;
  int n_pass;

  full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .c_in(ci1),
    .sum(s1), .c_out(co1), .out_valid(ov1));

  full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .c_in(ci8),
    .sum(s8), .c_out(co8), .out_valid(ov8));

  full_adder #(.WIDTH(4), .REG_OUT(1'b0)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .c_in(ci4),
    .sum(s4), .c_out(co4), .out_valid(ov4));

  full_adder #(.WIDTH(16), .REG_OUT(1'b1)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16), .c_in(ci16),
    .sum(s16), .c_out(co16), .out_valid(ov16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: full (w+1)-bit unsigned sum.
  function automatic logic [63:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input int w);
    logic [64:0] t;
    t = {1'b0, x} + {1'b0, y} + {64'd0, ci};
    return t[63:0] & ((64'd1 << (w + 1)) - 64'd1);
  endfunction

  // WIDTH=1 truth table, indexed by {a,b,c_in}, entries {sum,c_out}.
  logic [1:0] tt [8];

  initial begin
    logic [63:0] held16;
    logic [63:0] expv;
    n_checks = 0;
    n_pass   = 0;
    tt[0] = 2'b00; tt[1] = 2'b10; tt[2] = 2'b10; tt[3] = 2'b01;
    tt[4] = 2'b10; tt[5] = 2'b01; tt[6] = 2'b01; tt[7] = 2'b11;

    rst_n = 1'b0;
    {v1, a1, b1, ci1} = 4'b0000;
    v8 = 1'b0; a8 = 8'd0; b8 = 8'd0; ci8 = 1'b0;
    v4 = 1'b0; a4 = 4'd0; b4 = 4'd0; ci4 = 1'b0;
    v16 = 1'b0; a16 = 16'd0; b16 = 16'd0; ci16 = 1'b0;

    // Reset state
    #12;
    check_eq("rst_w8_sum", {55'd0, co8, s8}, 64'd0);
    check_eq("rst_w8_ov", {63'd0, ov8}, 64'd0);
    check_eq("rst_w1", {61'd0, s1, co1, ov1}, 64'd0);
    check_eq("rst_w16", {46'd0, ov16, co16, s16}, 64'd0);
    rst_n = 1'b1;

    // WIDTH=1 truth table, back-to-back
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v1 = 1'b1;
      {a1, b1, ci1} = 3'(i);
      @(posedge clk); #1;
      check_eq($sformatf("tt_%0d", i), {62'd0, s1, co1}, {62'd0, tt[i]});
      check_eq($sformatf("tt_ov_%0d", i), {63'd0, ov1}, 64'd1);
    end
    @(negedge clk);
    v1 = 1'b0;

    // WIDTH=8 directed vectors
    @(negedge clk);
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1;
    @(posedge clk); #1;
    check_eq("w8_ff_00_1", {55'd0, co8, s8}, 64'h100);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    @(posedge clk); #1;
    check_eq("w8_ff_ff_1", {55'd0, co8, s8}, 64'h1FF);
    check_eq("w8_ov_b2b", {63'd0, ov8}, 64'd1);
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h25; ci8 = 1'b0;
    @(posedge clk); #1;
    check_eq("w8_5a_25_0", {55'd0, co8, s8}, 64'h07F);

    // Hold with in_valid low
    @(negedge clk);
    v8 = 1'b0; a8 = 8'h01; b8 = 8'h02; ci8 = 1'b1;
    @(posedge clk); #1;
    check_eq("w8_hold_sum", {55'd0, co8, s8}, 64'h07F);
    check_eq("w8_hold_ov", {63'd0, ov8}, 64'd0);

    // Reset between edges
    @(negedge clk);
    v8 = 1'b1; a8 = 8'h03; b8 = 8'h04; ci8 = 1'b0;
    @(posedge clk); #1;
    check_eq("w8_pre_rst", {55'd0, co8, s8}, 64'h007);
    #1 rst_n = 1'b0;
    #1;
    check_eq("w8_rst_async", {54'd0, ov8, co8, s8}, 64'd0);
    a8 = 8'h10; b8 = 8'h20; ci8 = 1'b1;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("w8_post_rst", {55'd0, co8, s8}, ref_add(64'h10, 64'h20, 1'b1, 8));
    check_eq("w8_post_rst_ov", {63'd0, ov8}, 64'd1);
    @(negedge clk);
    v8 = 1'b0;

    // Combinational WIDTH=4
    v4 = 1'b1; a4 = 4'h9; b4 = 4'h8; ci4 = 1'b1;
    #1;
    check_eq("w4_9_8_1", {59'd0, co4, s4}, 64'h12);
    check_eq("w4_ov_hi", {63'd0, ov4}, 64'd1);
    v4 = 1'b0;
    #1;
    check_eq("w4_ov_lo", {63'd0, ov4}, 64'd0);
    for (int i = 0; i < 40; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom);
      v4 = 1'($urandom);
      #1;
      check_eq("w4_rand", {59'd0, co4, s4}, ref_add({60'd0, a4}, {60'd0, b4}, ci4, 4));
      check_eq("w4_rand_ov", {63'd0, ov4}, {63'd0, v4});
    end

    // Random WIDTH=16 with random in_valid; model tracks held result
    held16 = 64'd0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
      if ((i % 50) == 0) begin
        a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1;
      end
      v16 = ($urandom_range(0, 3) != 0);
      expv = ref_add({48'd0, a16}, {48'd0, b16}, ci16, 16);
      if (v16) held16 = expv;
      @(posedge clk); #1;
      check_eq("w16_res", {47'd0, co16, s16}, held16);
      check_eq("w16_ov", {63'd0, ov16}, {63'd0, v16});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Parameterised binary full adder: adds two WIDTH-bit operands and a carry-in, producing a WIDTH-bit sum and a carry-out.
- Built as a ripple chain of 1-bit full-adder cells, followed by an optional output register stage with a valid flag.
- Used as the leaf arithmetic primitive in datapaths. With WIDTH=1 it is the classic 1-bit full adder.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).
- REG_OUT, 1, 1 = sum/c_out/out_valid registered (1-cycle latency); 0 = purely combinational outputs.

Ports:
- clk  input  1  rising-edge clock; used only when REG_OUT=1.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies a, b, c_in for capture.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry-in.
- sum  output  WIDTH  (a + b + c_in) mod 2^WIDTH.
- c_out  output  1  bit WIDTH of (a + b + c_in).
- out_valid  output  1  sum/c_out hold a valid result.

Behaviour:
- Bit cell i:
  - s[i] = a[i] ^ b[i] ^ k[i]
  - k[i+1] = (a[i] & b[i]) | (a[i] & k[i]) | (b[i] & k[i])
  - k[0] = c_in; c_out = k[WIDTH].
- Arithmetic: {c_out, sum} equals the full (WIDTH+1)-bit unsigned sum of a + b + c_in. No saturation, no signed overflow flag.
- WIDTH=1 truth table (a b c_in -> sum c_out): 000->00, 001->10, 010->10, 011->01, 100->10, 101->01, 110->01, 111->11.
- REG_OUT=1:
  - On a rising clk edge with in_valid=1: sum and c_out capture the combinational result.
  - On every rising edge: out_valid <= in_valid.
  - With in_valid=0: sum and c_out hold their previous values; out_valid goes 0.
  - Latency is exactly 1 cycle. Back-to-back valid inputs give back-to-back valid outputs (throughput 1/cycle).
- REG_OUT=0:
  - sum and c_out follow the inputs combinationally regardless of in_valid; out_valid = in_valid.
  - clk and rst_n are unused.
- Reset (REG_OUT=1):
  - rst_n low asynchronously forces sum=0, c_out=0, out_valid=0, independent of clk.
  - An operation in flight when reset asserts is discarded.
  - The first capture after release occurs on the first rising edge with rst_n=1 and in_valid=1.
- Boundaries:
  - All-ones + all-ones + 1 gives sum = all-ones, c_out=1.
  - All-zeros + all-zeros + 0 gives 0, 0.
  - X on unused upper bits is not permitted (WIDTH is exact).
- No handshake back-pressure: the block always accepts input.

Decomposition:
- No shared package types required. A package constant for the maximum supported WIDTH (64) may live in the common arithmetic package.
- One natural sub-module: fa_bit (1-bit full-adder cell: a, b, cin -> s, cout), instantiated WIDTH times via a generate loop to form the ripple chain.
- The output register stage stays in full_adder under a generate on REG_OUT.

Test Plan:
- WIDTH=1, REG_OUT=1, in_valid=1: apply all 8 {a,b,c_in} combinations on consecutive cycles -> one cycle later, each sum/c_out matches the truth table above, with out_valid=1 throughout.
- WIDTH=8: a=8'hFF, b=8'h00, c_in=1 -> sum=8'h00, c_out=1. Then a=8'hFF, b=8'hFF, c_in=1 -> sum=8'hFF, c_out=1. Then a=8'h5A, b=8'h25, c_in=0 -> sum=8'h7F, c_out=0.
- Hold: after a valid result of 8'h7F, drive in_valid=0 with new operands -> sum stays 8'h7F, out_valid=0.
- Reset mid-operation: capture a valid result, then pulse rst_n low between clock edges -> sum=0, c_out=0, out_valid=0 immediately. After release, the next valid input appears 1 cycle later.
- REG_OUT=0, WIDTH=4: a=4'h9, b=4'h8, c_in=1 -> sum=4'h2, c_out=1 in the same delta, with out_valid tracking in_valid.
- Random: 10k random a/b/c_in at WIDTH=16 -> {c_out,sum} equals the reference model a+b+c_in on every valid output.
